commit_trace_tx: RTL and testbench

Hardware commit-trace transmitter for the 5-stage pipelined RISC-V CPU. It captures each write-back commit (PC, rd, data) plus pipeline stall/flush events into a small FIFO. It serializes each record as a 10-byte packet onto a byte-wide valid/ready stream for a UART or debug bridge. It sits beside `top`, tapping write-back-stage and hazard-unit signals, and gives silicon the same visibility the simulation monitors give.

---
 rtl/commit_trace_tx.sv | 137 +++++++++++++
 tb/tb_commit_trace_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: captures write-back commits and hazard flags, then streams 10-byte packets.
// A capture into an empty idle FIFO shows byte 0 one edge later; tx_data/tx_valid hold while tx_ready is low.
module commit_trace_tx #(
  parameter int DEPTH   = 8,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [31:0]              wb_pc,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     stall_evt,
  input  logic                     flush_evt,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              dropped_cnt,
  output logic                     busy
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [7:0]  SYNC     = 8'hA5;

  typedef struct packed {
    logic        drop;
    logic        stall;
    logic        flush;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] data;
  } rec_t;

  typedef enum logic {IDLE, SEND} state_t;

  rec_t        mem [DEPTH];
  rec_t        pkt;
  rec_t        rec_in;
  state_t      state;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [3:0]  idx;
  logic        stall_seen;
  logic        flush_seen;
  logic        drop_seen;
  logic        cap;
  logic        push;
  logic        pop;
  logic        drop;
  logic        hs;
  logic        last;
  logic        empty;
  logic        full;

  assign fifo_level = wr_ptr - rd_ptr;
  assign empty      = (fifo_level == '0);
  assign full       = (fifo_level == FULL_LVL);
  assign hs         = tx_valid && tx_ready;
  assign last       = hs && (idx == 4'd9);
  assign pop        = !empty && ((state == IDLE) || last);
  assign cap        = wb_valid && !(SKIP_X0 && (wb_rd == 5'd0));
  assign push       = cap && (!full || pop);
  assign drop       = cap && !push;
  assign busy       = !empty || (state == SEND);
  assign rec_in     = {drop_seen, stall_seen | stall_evt, flush_seen | flush_evt,
                       wb_rd, wb_pc, wb_data};

  function automatic logic [7:0] pkt_byte(input rec_t r, input logic [3:0] i);
    case (i)
      4'd0:    pkt_byte = SYNC;
      4'd1:    pkt_byte = {r.drop, r.stall, r.flush, r.rd};
      4'd2:    pkt_byte = r.pc[7:0];
      4'd3:    pkt_byte = r.pc[15:8];
      4'd4:    pkt_byte = r.pc[23:16];
      4'd5:    pkt_byte = r.pc[31:24];
      4'd6:    pkt_byte = r.data[7:0];
      4'd7:    pkt_byte = r.data[15:8];
      4'd8:    pkt_byte = r.data[23:16];
      4'd9:    pkt_byte = r.data[31:24];
      default: pkt_byte = 8'h00;
    endcase
  endfunction

  // When full with a simultaneous pop, write and read hit the same slot; the pop sees the old record.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dropped_cnt <= '0;
      stall_seen  <= 1'b0;
      flush_seen  <= 1'b0;
      drop_seen   <= 1'b0;
      state       <= IDLE;
      pkt         <= '0;
      idx         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop && (dropped_cnt != 16'hFFFF)) dropped_cnt <= dropped_cnt + 16'd1;

      // Flags ride on the next accepted record; a dropped record leaves them pending.
      if (push) begin
        stall_seen <= 1'b0;
        flush_seen <= 1'b0;
        drop_seen  <= 1'b0;
      end else begin
        if (stall_evt) stall_seen <= 1'b1;
        if (flush_evt) flush_seen <= 1'b1;
        if (drop)      drop_seen  <= 1'b1;
      end

      if (pop) begin
        pkt      <= mem[rd_ptr[AW-1:0]];
        idx      <= '0;
        tx_data  <= SYNC;
        tx_valid <= 1'b1;
        state    <= SEND;
      end else if (last) begin
        idx      <= '0;
        tx_data  <= '0;
        tx_valid <= 1'b0;
        state    <= IDLE;
      end else if (hs) begin
        idx     <= idx + 4'd1;
        tx_data <= pkt_byte(pkt, idx + 4'd1);
      end
    end
  end
endmodule

// File: tb/tb_commit_trace_tx.sv
// Randomised and directed stimulus for commit_trace_tx, scored against a queue-based reference model.
module tb_commit_trace_tx;
  localparam int DEPTH = 8;
  localparam bit SKIP  = 1'b1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [31:0]   wb_pc;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          stall_evt;
  logic          flush_evt;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [LW-1:0] fifo_level;
  logic [15:0]   dropped_cnt;
  logic          busy;

  commit_trace_tx #(.DEPTH(DEPTH), .SKIP_X0(SKIP)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall_evt(stall_evt), .flush_evt(flush_evt),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .dropped_cnt(dropped_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int level;
    int dropped;
    bit valid;
    bit busy;
  } snap_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_bytes[$];
  snap_t      exp_snap[$];

  // Reference model: record count, packet-in-flight with bytes remaining, sticky flags.
  int m_n, m_rem, m_drop;
  bit m_inf, s_stall, s_flush, s_drop;
  // Inputs presented to the upcoming edge.
  bit          a_v, a_st, a_fl, a_rdy;
  logic [31:0] a_pc, a_d;
  logic [4:0]  a_rd;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_rem = 0; m_drop = 0; m_inf = 0;
    s_stall = 0; s_flush = 0; s_drop = 0;
    exp_bytes.delete();
    exp_snap.delete();
  endtask

  task automatic model_edge();
    bit hs, pop, cap;
    logic [7:0] b1;
    hs  = m_inf && a_rdy;
    pop = (m_n > 0) && (!m_inf || (hs && m_rem == 1));
    cap = a_v && !(SKIP && a_rd == 5'd0);
    if (hs) begin
      m_rem--;
      if (m_rem == 0) m_inf = 0;
    end
    if (pop) begin
      m_n--; m_inf = 1; m_rem = 10;
    end
    if (cap && m_n < DEPTH) begin
      b1 = {s_drop, s_stall | a_st, s_flush | a_fl, a_rd};
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(b1);
      for (int i = 0; i < 4; i++) exp_bytes.push_back(8'((a_pc >> (8*i)) & 32'hFF));
      for (int i = 0; i < 4; i++) exp_bytes.push_back(8'((a_d  >> (8*i)) & 32'hFF));
      m_n++;
      s_stall = 0; s_flush = 0; s_drop = 0;
    end else begin
      if (cap) begin
        if (m_drop < 65535) m_drop++;
        s_drop = 1;
      end
      s_stall |= a_st;
      s_flush |= a_fl;
    end
    exp_snap.push_back('{level: m_n, dropped: m_drop, valid: m_inf, busy: (m_n > 0) || m_inf});
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] d, input bit st, input bit fl, input bit rdy);
    @(posedge clk); #1;
    if (reset) model_edge();
    wb_valid = v; wb_pc = pc; wb_rd = rd; wb_data = d;
    stall_evt = st; flush_evt = fl; tx_ready = rdy;
    a_v = v; a_pc = pc; a_rd = rd; a_d = d; a_st = st; a_fl = fl; a_rdy = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    wb_valid = 0; wb_pc = 0; wb_rd = 0; wb_data = 0;
    stall_evt = 0; flush_evt = 0; tx_ready = 0;
    a_v = 0; a_pc = 0; a_rd = 0; a_d = 0; a_st = 0; a_fl = 0; a_rdy = 0;
    model_clear();
    #1;
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_dropped_cnt", int'(dropped_cnt), 0);
    check("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: per-cycle state against the model and each accepted byte against the byte scoreboard.
  always @(negedge clk) begin
    snap_t s;
    if (exp_snap.size() > 0) begin
      s = exp_snap.pop_front();
      check("fifo_level", int'(fifo_level), s.level);
      check("dropped_cnt", int'(dropped_cnt), s.dropped);
      check("tx_valid", int'(tx_valid), int'(s.valid));
      check("busy", int'(busy), int'(s.busy));
    end
    if (reset && tx_valid && tx_ready) begin
      if (exp_bytes.size() == 0) check("unexpected_byte", int'(tx_data), -1);
      else check("tx_byte", int'(tx_data), int'(exp_bytes.pop_front()));
    end
  end

  initial begin
    int guard;
    apply_reset();

    // Single commit, sink always ready.
    step(1, 32'h10, 5'd3, 32'h2A, 0, 0, 1);
    idle(14, 1);

    // x0 commit is filtered when SKIP_X0 is set.
    step(1, 32'h20, 5'd0, 32'h55, 0, 0, 1);
    idle(14, 1);

    // Sticky flags land in the next record, then clear.
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 32'h30, 5'd5, 32'h1234, 0, 0, 1);
    step(1, 32'h34, 5'd6, 32'h5678, 0, 0, 1);
    idle(24, 1);

    // Backpressure with ready pattern 1,0,0 repeating.
    step(1, 32'h10, 5'd3, 32'h2A, 0, 0, 1);
    for (int k = 0; k < 40; k++) step(0, 0, 0, 0, 0, 0, (k % 3) == 0);

    // Overflow: one packet stuck in flight, then 12 back-to-back commits.
    step(1, 32'h100, 5'd1, 32'hA0, 0, 0, 0);
    for (int k = 0; k < 12; k++) step(1, 32'h104 + 4*k, 5'(k + 2), 32'hB0 + k, 0, 0, 0);
    idle(3, 0);
    step(1, 32'h200, 5'd9, 32'hC0, 0, 0, 1);
    idle(60, 1);

    // Overflow again, then reset while byte 4 of a packet is on the wire.
    for (int k = 0; k < 14; k++) step(1, 32'h300 + 4*k, 5'(k + 1), 32'hD0 + k, 0, 0, 0);
    guard = 0;
    while (!(m_inf && m_rem == 6) && guard < 100) begin
      step(0, 0, 0, 0, 0, 0, 1);
      guard++;
    end
    check("reach_byte4_timeout", int'(guard < 100), 1);
    apply_reset();
    step(1, 32'hDEADBEEF, 5'd31, 32'hCAFEF00D, 1, 0, 1);
    idle(14, 1);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      step(($urandom % 3) != 0, $urandom, 5'($urandom), $urandom,
           ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0);

    // Drain.
    guard = 0;
    while ((m_n > 0 || m_inf) && guard < 2000) begin
      step(0, 0, 0, 0, 0, 0, 1);
      guard++;
    end
    check("drain_timeout", int'(guard < 2000), 1);
    idle(2, 1);
    check("bytes_outstanding", exp_bytes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
